// File: rtl/pipeline_mem_arbiter_if.sv
// Pipeline-side and system-bus-side signals of the pipeline memory arbiter.
// The arbiter connects through the master modport; the surrounding pipeline
// and bus model connect through the slave modport.
interface pipeline_mem_arbiter_if;
  // Instruction-fetch requester
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  // Memory-stage requester
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic        data_ready;
  logic [31:0] data_read_data;
  // System bus
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_ready;
  logic [31:0] bus_read_data;
  logic        bus_timeout;
  // Pipeline freeze
  logic        stall_fetch;
  logic        stall_mem;

  modport master (
    input  fetch_req, fetch_address,
    input  data_read, data_write, data_address, data_write_data, data_byte_enable,
    input  bus_ready, bus_read_data,
    output fetch_ready, fetch_data, data_ready, data_read_data,
    output bus_valid, bus_write, bus_address, bus_write_data, bus_byte_enable,
    output bus_timeout, stall_fetch, stall_mem
  );

  modport slave (
    output fetch_req, fetch_address,
    output data_read, data_write, data_address, data_write_data, data_byte_enable,
    output bus_ready, bus_read_data,
    input  fetch_ready, fetch_data, data_ready, data_read_data,
    input  bus_valid, bus_write, bus_address, bus_write_data, bus_byte_enable,
    input  bus_timeout, stall_fetch, stall_mem
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one single-ported memory bus between the fetch stage and the memory
// stage. Data requests have priority; the requester that is receiving its
// ready pulse is masked for that cycle so a request the pipeline is about to
// drop is not granted a second time.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort bus transfers that wait
// longer than TIMEOUT_CYCLES for bus_ready (reported through bus_timeout).
module pipeline_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_mem_arbiter_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_FETCH,
    BUSY_DATA,
    RESP_FETCH,
    RESP_DATA
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  state_t      state_reg;
  logic        bus_valid_reg;
  logic        bus_write_reg;
  logic [31:0] bus_address_reg;
  logic [31:0] bus_write_data_reg;
  logic [3:0]  bus_byte_enable_reg;
  logic        fetch_ready_reg;
  logic        data_ready_reg;
  logic [31:0] fetch_data_reg;
  logic [31:0] data_read_data_reg;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             bus_timeout_reg;
`endif

  logic grant_phase;
  logic data_req_masked;
  logic fetch_req_masked;
  logic grant_data;
  logic grant_fetch;

  // Grant decision: only between accesses, data first, just-served requester masked
  assign grant_phase      = (state_reg == IDLE) || (state_reg == RESP_FETCH) || (state_reg == RESP_DATA);
  assign data_req_masked  = (mem.data_read || mem.data_write) && (state_reg != RESP_DATA);
  assign fetch_req_masked = mem.fetch_req && (state_reg != RESP_FETCH);
  assign grant_data       = grant_phase && data_req_masked;
  assign grant_fetch      = grant_phase && !data_req_masked && fetch_req_masked;

  // Arbiter FSM with registered bus request and registered responses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg           <= IDLE;
      bus_valid_reg       <= 1'b0;
      bus_write_reg       <= 1'b0;
      bus_address_reg     <= 32'h0;
      bus_write_data_reg  <= 32'h0;
      bus_byte_enable_reg <= 4'h0;
      fetch_ready_reg     <= 1'b0;
      data_ready_reg      <= 1'b0;
      fetch_data_reg      <= NOP_INSTR;
      data_read_data_reg  <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_reg        <= '0;
      bus_timeout_reg     <= 1'b0;
`endif
    end else begin
      fetch_ready_reg <= 1'b0;
      data_ready_reg  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE, RESP_FETCH, RESP_DATA: begin
          if (grant_data) begin
            state_reg           <= BUSY_DATA;
            bus_valid_reg       <= 1'b1;
            // A simultaneous read and write is treated as a store
            bus_write_reg       <= mem.data_write;
            bus_address_reg     <= mem.data_address;
            bus_write_data_reg  <= mem.data_write_data;
            bus_byte_enable_reg <= mem.data_write ? mem.data_byte_enable : 4'hF;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_reg        <= '0;
`endif
          end else if (grant_fetch) begin
            state_reg           <= BUSY_FETCH;
            bus_valid_reg       <= 1'b1;
            bus_write_reg       <= 1'b0;
            bus_address_reg     <= mem.fetch_address;
            bus_write_data_reg  <= 32'h0;
            bus_byte_enable_reg <= 4'hF;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_reg        <= '0;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        BUSY_FETCH, BUSY_DATA: begin
          if (mem.bus_ready) begin
            bus_valid_reg <= 1'b0;
            if (state_reg == BUSY_FETCH) begin
              fetch_data_reg  <= mem.bus_read_data;
              fetch_ready_reg <= 1'b1;
              state_reg       <= RESP_FETCH;
            end else begin
              if (!bus_write_reg) begin
                data_read_data_reg <= mem.bus_read_data;
              end
              data_ready_reg <= 1'b1;
              state_reg      <= RESP_DATA;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
            // Abort: release the bus and hand back a harmless result
            bus_valid_reg   <= 1'b0;
            bus_timeout_reg <= 1'b1;
            if (state_reg == BUSY_FETCH) begin
              fetch_data_reg  <= NOP_INSTR;
              fetch_ready_reg <= 1'b1;
              state_reg       <= RESP_FETCH;
            end else begin
              data_read_data_reg <= 32'h0;
              data_ready_reg     <= 1'b1;
              state_reg          <= RESP_DATA;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        default: begin
          state_reg     <= IDLE;
          bus_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem.bus_valid       = bus_valid_reg;
  assign mem.bus_write       = bus_write_reg;
  assign mem.bus_address     = bus_address_reg;
  assign mem.bus_write_data  = bus_write_data_reg;
  assign mem.bus_byte_enable = bus_byte_enable_reg;
  assign mem.fetch_ready     = fetch_ready_reg;
  assign mem.fetch_data      = fetch_data_reg;
  assign mem.data_ready      = data_ready_reg;
  assign mem.data_read_data  = data_read_data_reg;

`ifdef MEM_ARB_TIMEOUT_EN
  assign mem.bus_timeout = bus_timeout_reg;
`else
  assign mem.bus_timeout = 1'b0;
`endif

  // Pipeline freezes while its request is pending and not yet answered
  assign mem.stall_fetch = mem.fetch_req && !fetch_ready_reg;
  assign mem.stall_mem   = (mem.data_read || mem.data_write) && !data_ready_reg;

endmodule
